// File: rtl/multiplexer.sv
// Purpose: four-input WIDTH-bit selector with a combinational copy (Y) and a registered copy (X, X_valid).
// Latency: Y is 0 cycles (combinational); X and X_valid update 1 cycle after an enabled edge.
// Backpressure: none; every enabled edge captures a new value, en=0 holds the register.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset; clears X and X_valid, overrides en
//   en       capture enable for the output register
//   A..D     data sources 0..3, WIDTH bits each
//   SEL      source select: 00->A, 01->B, 10->C, 11->D
//   X        registered selected value
//   X_valid  high once X holds a captured value since the last reset
//   Y        combinational selected value, never reset
module multiplexer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       SEL,
    output logic [WIDTH-1:0] X,
    output logic             X_valid,
    output logic [WIDTH-1:0] Y
);

    logic [WIDTH-1:0] sel_val;

    // The default arm is reachable only with X/Z on SEL; it propagates
    // unknowns in simulation and is a don't-care for synthesis.
    always_comb begin
        sel_val = {WIDTH{1'bx}};
        case (SEL)
            2'b00:   sel_val = A;
            2'b01:   sel_val = B;
            2'b10:   sel_val = C;
            2'b11:   sel_val = D;
            default: sel_val = {WIDTH{1'bx}};
        endcase
    end

    assign Y = sel_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            X       <= '0;
            X_valid <= 1'b0;
        end else if (en) begin
            X       <= sel_val;
            X_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multiplexer.sv
// Purpose: self-checking bench for multiplexer at WIDTH=2 and WIDTH=8.
// Latency: model expects Y immediately and X one enabled edge later.
// Backpressure: none; stimulus is applied every cycle.
module tb_multiplexer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] sel;
    logic [1:0] a2, b2, c2, d2;
    logic [7:0] a8, b8, c8, d8;
    logic [1:0] x2, y2;
    logic [7:0] x8, y8;
    logic       xv2, xv8;

    int ntests = 0;
    int nfail  = 0;

    // Reference model state: what the output registers should hold.
    logic [7:0] exp_x2, exp_x8;
    logic       exp_v;

    always #5 clk = ~clk;

    multiplexer #(.WIDTH(2)) u_mux2 (
        .clk(clk), .rst(rst), .en(en),
        .A(a2), .B(b2), .C(c2), .D(d2), .SEL(sel),
        .X(x2), .X_valid(xv2), .Y(y2)
    );

    multiplexer #(.WIDTH(8)) u_mux8 (
        .clk(clk), .rst(rst), .en(en),
        .A(a8), .B(b8), .C(c8), .D(d8), .SEL(sel),
        .X(x8), .X_valid(xv8), .Y(y8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Source table lookup: element SEL of {A,B,C,D}.
    function automatic logic [7:0] pick(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d,
                                        input logic [1:0] s);
        logic [7:0] srcs[4];
        srcs = '{a, b, c, d};
        return srcs[s];
    endfunction

    task automatic check_y(input string tag);
        check({tag, "_y2"}, {30'd0, y2}, {24'd0, pick({6'd0, a2}, {6'd0, b2}, {6'd0, c2}, {6'd0, d2}, sel)});
        check({tag, "_y8"}, {24'd0, y8}, {24'd0, pick(a8, b8, c8, d8, sel)});
    endtask

    // Advance one edge, update the model from the inputs present at the edge,
    // then compare the registered outputs.
    task automatic tick(input string tag);
        logic [7:0] n2, n8;
        logic       r, e;
        n2 = pick({6'd0, a2}, {6'd0, b2}, {6'd0, c2}, {6'd0, d2}, sel);
        n8 = pick(a8, b8, c8, d8, sel);
        r  = rst;
        e  = en;
        @(posedge clk);
        #1;
        if (r) begin
            exp_x2 = 8'd0; exp_x8 = 8'd0; exp_v = 1'b0;
        end else if (e) begin
            exp_x2 = n2; exp_x8 = n8; exp_v = 1'b1;
        end
        check({tag, "_x2"}, {30'd0, x2}, {24'd0, exp_x2});
        check({tag, "_x8"}, {24'd0, x8}, {24'd0, exp_x8});
        check({tag, "_v2"}, {31'd0, xv2}, {31'd0, exp_v});
        check({tag, "_v8"}, {31'd0, xv8}, {31'd0, exp_v});
    endtask

    initial begin
        logic [1:0] sweep_exp2 [4];
        logic [7:0] sweep_exp8 [4];
        sweep_exp2 = '{2'b00, 2'b01, 2'b01, 2'b11};
        sweep_exp8 = '{8'hA5, 8'h3C, 8'hFF, 8'h00};

        exp_x2 = 8'd0; exp_x8 = 8'd0; exp_v = 1'b0;
        rst = 1'b1; en = 1'b0; sel = 2'b00;
        a2 = 2'd1; b2 = 2'd2; c2 = 2'd3; d2 = 2'd0;
        a8 = 8'h11; b8 = 8'h22; c8 = 8'h33; d8 = 8'h44;

        // Reset for two edges with arbitrary inputs and enable.
        for (int i = 0; i < 2; i++) begin
            sel = 2'($urandom);
            en  = 1'($urandom);
            #1 check_y("reset");
            tick("reset");
            check("reset_x_zero", {24'd0, x8}, 32'd0);
            check("reset_v_zero", {31'd0, xv2}, 32'd0);
        end

        // Select sweep with en=1.
        rst = 1'b0; en = 1'b1;
        a2 = 2'b00; b2 = 2'b01; c2 = 2'b01; d2 = 2'b11;
        a8 = 8'hA5; b8 = 8'h3C; c8 = 8'hFF; d8 = 8'h00;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check("sweep_y2_const", {30'd0, y2}, {30'd0, sweep_exp2[s]});
            check("sweep_y8_const", {24'd0, y8}, {24'd0, sweep_exp8[s]});
            tick("sweep");
            check("sweep_x2_const", {30'd0, x2}, {30'd0, sweep_exp2[s]});
            check("sweep_x8_const", {24'd0, x8}, {24'd0, sweep_exp8[s]});
            check("sweep_v_const", {31'd0, xv2}, 32'd1);
        end

        // Hold: capture D, then en=0 for three edges with SEL=00.
        sel = 2'b11;
        tick("hold_cap");
        en = 1'b0; sel = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_y2", {30'd0, y2}, 32'd0);
            tick("hold");
            check("hold_x2_const", {30'd0, x2}, 32'd3);
            check("hold_v_const", {31'd0, xv2}, 32'd1);
        end

        // Reset wins over a simultaneous enable.
        rst = 1'b1; en = 1'b1; sel = 2'b11; d2 = 2'b11;
        tick("rst_prio");
        check("rst_prio_x2", {30'd0, x2}, 32'd0);
        check("rst_prio_v", {31'd0, xv8}, 32'd0);
        rst = 1'b0;

        // SEL toggles between edges; only the value at the edge is captured.
        sel = 2'b00; #1 check_y("glitch0");
        sel = 2'b11; #1 check_y("glitch1");
        sel = 2'b01; #1 check_y("glitch2");
        tick("glitch");
        check("glitch_x2_const", {30'd0, x2}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(15) == 0);
            en  = 1'($urandom);
            a2 = 2'($urandom); b2 = 2'($urandom); c2 = 2'($urandom); d2 = 2'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom); d8 = 8'($urandom);
            sel = 2'($urandom);
            #1 check_y("rand");
            // Change inputs mid-cycle occasionally to confirm only edge values count.
            if ($urandom_range(3) == 0) begin
                sel = 2'($urandom);
                a8  = 8'($urandom);
                #1 check_y("rand_mid");
            end
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
